addsub_bist: RTL

- On-chip built-in self-test controller for the 2-bit adder/subtractor (`addsub`).
- It drives every `{m, a, b}` input combination into an `addsub` instance, then samples and checks `s`/`cout` against a golden model.
- It counts mismatches and reports pass/fail, so the adder/subtractor can be verified on the board without a simulator.
- It is the hardware response/checking end of the `addsub` interface.

---
 rtl/addsub_pkg.sv | 26 ++
 rtl/addsub_bist_ref_model.sv | 31 +++
 rtl/addsub_bist.sv | 133 +++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types, sizing and golden arithmetic for the 2-bit adder/subtractor BIST.
package addsub_pkg;

    localparam int ADDSUB_W = 2;
    localparam int IDXW     = 2 * ADDSUB_W + 1;
    localparam int NVEC     = 2 ** IDXW;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    // Subtraction is a + ~b + 1, so cout doubles as the "no borrow" (a >= b) flag.
    function automatic logic [ADDSUB_W:0] addsub_expect(
        input logic [ADDSUB_W-1:0] a,
        input logic [ADDSUB_W-1:0] b,
        input logic                m
    );
        logic [ADDSUB_W-1:0] bop;
        bop = m ? ~b : b;
        return {1'b0, a} + {1'b0, bop} + {{ADDSUB_W{1'b0}}, m};
    endfunction

endpackage

// File: rtl/addsub_bist_ref_model.sv
// Purely combinational golden model of the adder/subtractor: {o_cout, o_s}.
module addsub_ref_model
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_W
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_m,
    output logic [WIDTH-1:0] o_s,
    output logic             o_cout
);

    generate
        if (WIDTH == ADDSUB_W) begin : g_pkg
            logic [WIDTH:0] w_res;
            assign w_res  = addsub_expect(i_a, i_b, i_m);
            assign o_s    = w_res[WIDTH-1:0];
            assign o_cout = w_res[WIDTH];
        end else begin : g_generic
            // Same arithmetic as the package function, for non-default widths.
            logic [WIDTH-1:0] w_bop;
            logic [WIDTH:0]   w_res;
            assign w_bop  = i_m ? ~i_b : i_b;
            assign w_res  = {1'b0, i_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, i_m};
            assign o_s    = w_res[WIDTH-1:0];
            assign o_cout = w_res[WIDTH];
        end
    endgenerate

endmodule

// File: rtl/addsub_bist.sv
// BIST controller: sweeps every {m, a, b} into the adder/subtractor, checks against
// the golden model, and reports mismatch count, first failing index and pass/fail.
module addsub_bist
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    output logic                 dut_m,
    input  logic [WIDTH-1:0]     dut_s,
    input  logic                 dut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic                 fail_valid,
    output logic [2*WIDTH:0]     first_fail
);

    localparam int L_IDXW = 2 * WIDTH + 1;
    localparam int L_ERRW = 2 * WIDTH + 2;
    localparam int L_CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [L_CNTW-1:0] L_LOAD = L_CNTW'(SETTLE - 1);
    localparam logic [L_IDXW-1:0] L_LAST = {L_IDXW{1'b1}};

    state_t              r_state;
    state_t              w_state_next;
    logic [L_IDXW-1:0]   r_idx;
    logic [L_CNTW-1:0]   r_cnt;
    logic [L_ERRW-1:0]   r_err;
    logic [L_IDXW-1:0]   r_first;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                r_fail_valid;

    logic [WIDTH-1:0]    w_exp_s;
    logic                w_exp_cout;
    logic                w_mismatch;
    logic                w_accept;
    logic                w_last;

    addsub_ref_model #(.WIDTH(WIDTH)) u_ref (
        .i_a    (r_idx[2*WIDTH-1:WIDTH]),
        .i_b    (r_idx[WIDTH-1:0]),
        .i_m    (r_idx[2*WIDTH]),
        .o_s    (w_exp_s),
        .o_cout (w_exp_cout)
    );

    assign w_mismatch = ({dut_cout, dut_s} != {w_exp_cout, w_exp_s});
    assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last     = (r_idx == L_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = DRIVE;
            DRIVE:   if (r_cnt == '0) w_state_next = CHECK;
            CHECK:   w_state_next = w_last ? DONE : DRIVE;
            DONE:    if (start) w_state_next = DRIVE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_cnt        <= '0;
            r_err        <= '0;
            r_first      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
        end else if (w_accept) begin
            r_idx        <= '0;
            r_cnt        <= L_LOAD;
            r_err        <= '0;
            r_first      <= '0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
        end else if (r_state == DRIVE) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end else if (r_state == CHECK) begin
            if (w_mismatch) begin
                r_err <= r_err + 1'b1;
                if (!r_fail_valid) begin
                    r_first      <= r_idx;
                    r_fail_valid <= 1'b1;
                end
            end
            // idx holds the last vector after the final check until the next start.
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
                r_cnt <= L_LOAD;
            end
        end else if (r_state == DONE) begin
            r_done <= 1'b1;
            r_pass <= (r_err == '0);
        end
    end

    assign dut_m      = r_idx[2*WIDTH];
    assign dut_a      = r_idx[2*WIDTH-1:WIDTH];
    assign dut_b      = r_idx[WIDTH-1:0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign first_fail = r_first;

endmodule
